// File: rtl/sha_msg_sched_if.sv
// Block-in / schedule-word-out bundle for sha_msg_sched.
// When SCHED_XSUM_EN is defined the bundle also carries the running word sum xsum.
interface sha_msg_sched_if;
    logic         start;
    logic [511:0] block;
    logic         en;
    logic         ready;
    logic         w_valid;
    logic [31:0]  w_out;
    logic [5:0]   w_idx;
    logic         done;
`ifdef SCHED_XSUM_EN
    logic [31:0]  xsum;

    modport master (output start, block, en,
                    input  ready, w_valid, w_out, w_idx, done, xsum);
    modport slave  (input  start, block, en,
                    output ready, w_valid, w_out, w_idx, done, xsum);
`else
    modport master (output start, block, en,
                    input  ready, w_valid, w_out, w_idx, done);
    modport slave  (input  start, block, en,
                    output ready, w_valid, w_out, w_idx, done);
`endif
endinterface

// File: rtl/sha_msg_sched.sv
// SHA-256 message schedule expander: 16-word sliding window, one W[t] per advance.
// Optional SCHED_XSUM_EN adds xsum, a running mod-2^32 sum of consumed words.
module sha_msg_sched #(
    parameter int unsigned ROUNDS = 64
) (
    input  logic             clk,
    input  logic             rst,
    sha_msg_sched_if.slave   bus
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned WIN_N  = 16;
    localparam int unsigned IDX_W  = 6;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [WORD_W-1:0] win     [WIN_N];
    logic [WORD_W-1:0] win_nxt [WIN_N];
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic              ready_q, valid_q, done_q;
    logic [WORD_W-1:0] new_word_c;
`ifdef SCHED_XSUM_EN
    logic [WORD_W-1:0] xsum_q, xsum_nxt;
`endif

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // W[t+16] from the window holding W[t..t+15]
    assign new_word_c = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        for (int i = 0; i < WIN_N; i++) win_nxt[i] = win[i];
`ifdef SCHED_XSUM_EN
        xsum_nxt  = xsum_q;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
                    for (int i = 0; i < WIN_N; i++)
                        win_nxt[i] = bus.block[(WIN_N-1-i)*WORD_W +: WORD_W];
                    idx_nxt   = '0;
                    state_nxt = RUN;
`ifdef SCHED_XSUM_EN
                    xsum_nxt  = '0;
`endif
                end
            end
            RUN: begin
                if (bus.en) begin
`ifdef SCHED_XSUM_EN
                    xsum_nxt = xsum_q + win[0];
`endif
                    if (idx == IDX_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        for (int i = 0; i < WIN_N-1; i++) win_nxt[i] = win[i+1];
                        win_nxt[WIN_N-1] = new_word_c;
                        idx_nxt          = idx + IDX_W'(1);
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            for (int i = 0; i < WIN_N; i++) win[i] <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef SCHED_XSUM_EN
            xsum_q  <= '0;
`endif
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            for (int i = 0; i < WIN_N; i++) win[i] <= win_nxt[i];
            ready_q <= (state_nxt == IDLE);
            valid_q <= (state_nxt == RUN);
            done_q  <= (state_nxt == DONE);
`ifdef SCHED_XSUM_EN
            xsum_q  <= xsum_nxt;
`endif
        end
    end

    assign bus.ready   = ready_q;
    assign bus.w_valid = valid_q;
    assign bus.w_out   = win[0];
    assign bus.w_idx   = idx;
    assign bus.done    = done_q;
`ifdef SCHED_XSUM_EN
    assign bus.xsum    = xsum_q;
`endif

endmodule

// File: tb/tb_sha_msg_sched.sv
// Scoreboard bench for sha_msg_sched (ROUNDS=64 and ROUNDS=16 instances).
// xsum checks are compiled in when SCHED_XSUM_EN is defined.
`timescale 1ns/1ps
module tb_sha_msg_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sha_msg_sched_if bus();
    sha_msg_sched_if bus16();

    sha_msg_sched #(.ROUNDS(64)) dut   (.clk(clk), .rst(rst), .bus(bus));
    sha_msg_sched #(.ROUNDS(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] w;
    } exp_t;

    exp_t        q[$];
    exp_t        q16[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_w [64];
    logic [31:0] exp_sum;

    localparam logic [511:0] ABC = {32'h61626380, {14{32'h00000000}}, 32'h00000018};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference: plain FIPS 180-4 recurrence over a full W[] array
    task automatic model(input logic [511:0] b, input int rounds);
        for (int t = 0; t < 16; t++) exp_w[t] = b[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            exp_w[t] = (rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                     + exp_w[t-7]
                     + (rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                     + exp_w[t-16];
        exp_sum = 32'h0;
        for (int t = 0; t < rounds; t++) exp_sum = exp_sum + exp_w[t];
    endtask

    // Monitor for the 64-round instance
    initial begin
        logic        last_prev;
        logic        hold_prev;
        logic [37:0] held;
        exp_t        e;
        last_prev = 1'b0;
        hold_prev = 1'b0;
        held      = '0;
        forever begin
            @(negedge clk);
            if (last_prev)     chk("done_after_last", 64'(bus.done), 64'd1);
            else if (bus.done) chk("done_spurious", 64'(bus.done), 64'd0);
            if (hold_prev && bus.w_valid) chk("hold_on_stall", 64'({bus.w_idx, bus.w_out}), 64'(held));
            hold_prev = bus.w_valid && !bus.en && !rst;
            held      = {bus.w_idx, bus.w_out};
            last_prev = bus.w_valid && bus.en && !rst && (bus.w_idx == 6'd63);
            if (bus.w_valid && bus.en && !rst) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected_word", 64'(bus.w_idx), 64'hFFFF);
                end else begin
                    e = q.pop_front();
                    chk("w_idx", 64'(bus.w_idx), 64'(e.idx));
                    chk("w_out", 64'(bus.w_out), 64'(e.w));
                end
            end
        end
    end

    // Monitor for the 16-round instance
    initial begin
        logic last_prev;
        exp_t e;
        last_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (last_prev)       chk("r16_done_after_last", 64'(bus16.done), 64'd1);
            else if (bus16.done) chk("r16_done_spurious", 64'(bus16.done), 64'd0);
            last_prev = bus16.w_valid && bus16.en && !rst && (bus16.w_idx == 6'd15);
            if (bus16.w_valid && bus16.en && !rst) begin
                if (q16.size() == 0) begin
                    chk("r16_sb_unexpected_word", 64'(bus16.w_idx), 64'hFFFF);
                end else begin
                    e = q16.pop_front();
                    chk("r16_w_idx", 64'(bus16.w_idx), 64'(e.idx));
                    chk("r16_w_out", 64'(bus16.w_out), 64'(e.w));
                end
            end
        end
    end

    // Runs one block on the 64-round instance; called at posedge+1.
    // mode 1 stalls en (1,0,0,...); inj_idx pulses start with another block; rst_idx aborts.
    task automatic run_main(input logic [511:0] b, input int mode, input int inj_idx,
                            input int rst_idx, input logic abc);
        logic [511:0] other;
        logic         done_seen;
        logic         injected;
        other     = {16{32'hDEADBEEF}};
        done_seen = 1'b0;
        injected  = 1'b0;
        model(b, 64);
        if (abc) begin
            exp_w[16] = 32'h61626380;
            exp_w[17] = 32'h000F0000;
        end
        for (int t = 0; t < 64; t++) q.push_back({6'(t), exp_w[t]});
        chk("ready_before_start", 64'(bus.ready), 64'd1);
        bus.block = b;
        bus.start = 1'b1;
        bus.en    = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("first_word_valid", 64'(bus.w_valid), 64'd1);
        for (int c = 0; c < 400 && !done_seen; c++) begin
            bus.en    = (mode == 0) ? 1'b1 : ((c % 3) == 0);
            bus.start = 1'b0;
            if (inj_idx >= 0 && !injected && bus.w_valid && bus.w_idx == 6'(inj_idx)) begin
                bus.start = 1'b1;
                bus.block = other;
                injected  = 1'b1;
                chk("ready_low_in_run", 64'(bus.ready), 64'd0);
            end
            if (rst_idx >= 0 && bus.w_valid && bus.w_idx == 6'(rst_idx)) begin
                rst    = 1'b1;
                bus.en = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                chk("rst_ready", 64'(bus.ready), 64'd1);
                chk("rst_w_valid", 64'(bus.w_valid), 64'd0);
                chk("rst_w_idx", 64'(bus.w_idx), 64'd0);
                chk("rst_done", 64'(bus.done), 64'd0);
                q.delete();
                return;
            end
            @(posedge clk); #1;
            if (bus.done) done_seen = 1'b1;
        end
        bus.start = 1'b0;
        bus.en    = 1'b0;
        if (!done_seen) begin
            chk("done_timeout", 64'(done_seen), 64'd1);
            q.delete();
            return;
        end
        chk("done_w_valid", 64'(bus.w_valid), 64'd0);
        chk("done_ready", 64'(bus.ready), 64'd0);
`ifdef SCHED_XSUM_EN
        chk("xsum_at_done", 64'(bus.xsum), 64'(exp_sum));
`endif
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(bus.done), 64'd0);
        chk("ready_after_done", 64'(bus.ready), 64'd1);
        chk("sb_drained", 64'(q.size()), 64'd0);
`ifdef SCHED_XSUM_EN
        chk("xsum_after_done", 64'(bus.xsum), 64'(exp_sum));
`endif
    endtask

    initial begin
        logic [511:0] blk_b;
        logic         done16;
        for (int i = 0; i < 16; i++) blk_b[511-32*i -: 32] = 32'(i + 1) * 32'h9E3779B9;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.block   = '0;
        bus.en      = 1'b0;
        bus16.start = 1'b0;
        bus16.block = '0;
        bus16.en    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset_ready", 64'(bus.ready), 64'd1);
        chk("reset_w_valid", 64'(bus.w_valid), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_w_idx", 64'(bus.w_idx), 64'd0);
        chk("reset_w_out", 64'(bus.w_out), 64'd0);
`ifdef SCHED_XSUM_EN
        chk("reset_xsum", 64'(bus.xsum), 64'd0);
`endif

        // rst and start together: reset wins
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.block = ABC;
        @(posedge clk); #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        chk("rst_start_ready", 64'(bus.ready), 64'd1);
        chk("rst_start_w_valid", 64'(bus.w_valid), 64'd0);
        @(posedge clk); #1;
        chk("rst_start_still_idle", 64'(bus.w_valid), 64'd0);

        run_main(ABC, 0, -1, -1, 1'b1);
        run_main('0, 0, -1, -1, 1'b0);
        run_main(ABC, 1, -1, -1, 1'b1);
        run_main(blk_b, 0, 20, -1, 1'b0);
        run_main(ABC, 0, -1, -1, 1'b1);
        run_main(ABC, 0, -1, 30, 1'b1);
        repeat (3) @(posedge clk);
        #1 chk("no_done_after_rst", 64'(bus.done), 64'd0);
        run_main(ABC, 0, -1, -1, 1'b1);

        // ROUNDS=16: output is exactly the input words
        for (int t = 0; t < 16; t++) q16.push_back({6'(t), ABC[511-32*t -: 32]});
        done16      = 1'b0;
        bus16.block = ABC;
        bus16.start = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        bus16.en    = 1'b1;
        for (int c = 0; c < 100 && !done16; c++) begin
            @(posedge clk); #1;
            if (bus16.done) done16 = 1'b1;
        end
        bus16.en = 1'b0;
        chk("r16_done_seen", 64'(done16), 64'd1);
`ifdef SCHED_XSUM_EN
        chk("r16_xsum", 64'(bus16.xsum), 64'h61626398);
`endif
        @(posedge clk); #1;
        chk("r16_ready_after_done", 64'(bus16.ready), 64'd1);
        chk("r16_sb_drained", 64'(q16.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/sha_msg_sched.md
Name: sha_msg_sched

Overview:
- Downstream consumer of the 512-bit message-block shift register.
- Takes one assembled 512-bit block and expands it into the SHA-256 message schedule W[0..ROUNDS-1].
- Emits one 32-bit word per advance to the compression/round stage.
- Holds a 16-word sliding window; one schedule word is computed per advance.

Parameters:
- ROUNDS, 64, number of schedule words emitted per block; legal range 16..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request to load `block`; accepted only when ready=1
- block  input  512  message block; W0 = block[511:480], W1 = block[479:448], ..., W15 = block[31:0]
- en  input  1  consumer advance; the current word is consumed on a cycle with w_valid & en
- ready  output  1  idle, able to accept start
- w_valid  output  1  w_out/w_idx are valid
- w_out  output  32  current schedule word W[w_idx]
- w_idx  output  6  index of the current word, 0..ROUNDS-1
- done  output  1  one-cycle pulse after the last word is consumed

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high on rst, sampled on the rising edge of clk.
- Reset values: state=IDLE, ready=1, w_valid=0, done=0, w_idx=0, w_out=0, window cleared.
- State machine:
  - IDLE: ready=1. On start=1, load window win[i] = W_i for i=0..15, set w_idx=0, go to RUN.
  - RUN: w_valid=1, w_out=win[0].
    - On en=1 with w_idx<ROUNDS-1: shift win[i] <= win[i+1] for i=0..14, win[15] <= new word, w_idx++.
    - On en=1 with w_idx=ROUNDS-1: go to DONE.
    - On en=0: hold all state.
  - DONE: done=1, w_valid=0, ready=0 for exactly one cycle, then go to IDLE.
- New word: win[15]' = s1(win[14]) + win[9] + s0(win[1]) + win[0], modulo 2^32 with carries discarded. This equals W[t+16] when win[0]=W[t].
  - s0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x)
  - s1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
- Latency: start accepted at edge k; W0 is valid in the cycle after edge k. With en held high, one word per cycle; done rises the cycle after W[ROUNDS-1] is consumed.
- start outside IDLE (RUN or DONE) is ignored; `block` is sampled only on the accepting edge.
- Words for indices >= 16 are computed even when ROUNDS=16 but never emitted; for ROUNDS=16 the output is exactly the input words.
- The idle-to-load transition needs no en.
- rst asserted mid-RUN: the next edge returns to reset values. No done pulse; the partial block is discarded.
- rst and start asserted together: rst wins.
- w_out and w_idx are registered/derived from the window and counter only; there is no combinational path from en or start to them.

Optional Feature:
- Macro: SCHED_XSUM_EN.
- Defined: adds output port `xsum` (32 bits), a running modulo-2^32 sum of every consumed word (w_valid & en).
  - Cleared by reset and on start acceptance.
  - Stable during and after DONE until the next accepted start.
  - Used for bring-up checking against the software model.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- "abc" padded block: start with W0=0x61626380, W1..W14=0, W15=0x00000018, en=1 -> W0..W15 echo the input; W16=0x61626380, W17=0x000F0000; all 64 words match the SHA-256 software model; done pulses one cycle after w_idx=63.
- All-zero block -> w_out=0 for all 64 words, w_idx counts 0..63, done pulses once, ready returns to 1 the cycle after done.
- en stall: toggle en 1,0,0,1,... during RUN -> w_out/w_idx hold on en=0 cycles; sequence identical to the unstalled run; no index skipped or repeated.
- start pulsed with a different block at w_idx=20 -> ignored; output continues the original schedule; the new block is accepted only after returning to IDLE.
- rst asserted at w_idx=30 -> next cycle ready=1, w_valid=0, w_idx=0, no done pulse; a subsequent "abc" run is correct.
- ROUNDS=16 build, "abc" block -> 16 words equal to the input, then done. With SCHED_XSUM_EN defined: xsum = 0x61626398 after done.
